fg_packet_gen: RTL
==================

// Module: fg_packet_gen
// PURPOSE
// - Stage directly downstream of the flow generator's burst generator: consumes burst
//   descriptors (dest, burst_len in bytes) and emits them as AXI-stream packets.
// - Each burst is split into packets of at most max_pkt_len bytes. Payload is a byte
//   counter: byte value = burst byte offset mod 256. Output feeds the MAC/traffic sink.
// PARAMETERS
// - DATA_WIDTH  64  AXI-stream data width in bits; multiple of 8.
// - KEEP_WIDTH  DATA_WIDTH/8  tkeep width; bytes per beat.
// - DEST_WIDTH  8   width of the dest field on input and tdest on output.
// - LEN_WIDTH   32  width of burst_len and of the byte counter.
// PORTS
// - clk                  in   1           clock
// - rst_n                in   1           synchronous reset, active low
// - input_bd_valid       in   1           burst descriptor valid
// - input_bd_ready       out  1           burst descriptor ready
// - input_bd_dest        in   DEST_WIDTH  destination for all packets of the burst
// - input_bd_burst_len   in   LEN_WIDTH   burst length in bytes
// - output_axis_tdata    out  DATA_WIDTH  payload
// - output_axis_tkeep    out  KEEP_WIDTH  byte enables, contiguous from bit 0
// - output_axis_tvalid   out  1           beat valid
// - output_axis_tready   in   1           beat accepted downstream
// - output_axis_tlast    out  1           last beat of packet
// - output_axis_tdest    out  DEST_WIDTH  = latched input_bd_dest
// - max_pkt_len          in   16          config: max packet bytes; 0 treated as 1
// - busy                 out  1           high while a burst is being sent
// - bursts_done          out  32          count of completed bursts (wraps)
// - bytes_sent           out  LEN_WIDTH   count of payload bytes transferred (wraps)
// BEHAVIOUR
// - Clock clk; reset rst_n synchronous, active low. During reset: input_bd_ready=0,
//   tvalid=0, tlast=0, tdata/tkeep/tdest=0, busy=0, bursts_done=0, bytes_sent=0,
//   FSM=IDLE. input_bd_ready goes high on the first cycle after reset is released.
// - FSM IDLE: input_bd_ready=1. On valid&&ready, latch dest, burst_len, and max_pkt_len
//   (0 -> 1). Go to SEND; burst_len==0 -> stay IDLE, bursts_done+1, no output.
// - SEND: input_bd_ready=0, busy=1. First beat tvalid is asserted in the cycle after
//   descriptor acceptance (latency 1).
// - Beat: nbytes = min(KEEP_WIDTH, pkt_rem); tkeep = (1<<nbytes)-1; byte k =
//   (offset+k)[7:0]; bytes above nbytes are 0. tlast = (pkt_rem <= KEEP_WIDTH).
// - pkt_rem = min(max_pkt_len, burst_rem) at each packet start.
// - AXIS rules: once tvalid=1, tdata/tkeep/tlast/tdest stay stable until tready; no
//   dependence of tvalid on tready. Beat transfer: offset += nbytes, bytes_sent += nbytes.
// - Back-to-back: after a tlast transfer with burst_rem>0, next packet's first beat is
//   valid the next cycle (no bubble). After the final beat transfers: bursts_done+1, back
//   to IDLE; ready=1 the next cycle. Minimum one idle cycle between bursts.
// - Arithmetic in LEN_WIDTH; burst_len=2^LEN_WIDTH-1 must complete correctly; status
//   counters wrap silently.
// - max_pkt_len changes mid-burst have no effect (value latched per burst).
// - Reset mid-burst: burst dropped immediately, no tlast emitted, counters cleared.
// STRUCTURE
// - Package fg_pkg: localparam states (ST_IDLE, ST_SEND); shared burst-descriptor field
//   widths matching the burst generator (DEST_WIDTH, LEN_WIDTH).
// - Sub-module fg_beat_fill: combinational (offset, nbytes) -> (tdata, tkeep).
//   Everything else (FSM, counters, output regs) lives in fg_packet_gen.
// TESTING
// - T1: dest=0x12, len=20, max=64, tready=1 -> 3 beats: tkeep FF,FF,0F; tlast on beat 3;
//   bytes 0x00..0x13; tdest=0x12; bursts_done=1, bytes_sent=20.
// - T2: len=100, max=40 -> packets of 40,40,20 bytes. Beats per pkt 5,5,3; tlast on
//   beats 5,10,13; no bubble between packets; byte 40 = 0x28.
// - T3: len=0 then len=8 -> no beats for first; bursts_done=1; second gives one beat,
//   tkeep=FF, tlast=1; bursts_done=2.
// - T4: len=300, max=0 -> 300 one-byte packets, tkeep=01 each, tlast every beat.
//   Byte 256 wraps to 0x00.
// - T5: random tready (50%) on len=1000, max=256 -> data/tkeep/tlast stable while
//   stalled. Scoreboard matches byte counter; bytes_sent=1000.
// - T6: rst_n low during beat 3 of len=64 -> next cycle tvalid=0, busy=0, counters=0.
//   New descriptor after release starts offset at 0x00.

Source files
------------

// File: rtl/fg_pkg.sv
// Shared definitions for the flow-generator packet stage: FSM states and the
// burst-descriptor field widths used by the upstream burst generator.
package fg_pkg;

    localparam int BD_DEST_WIDTH = 8;
    localparam int BD_LEN_WIDTH  = 32;
    localparam int MAX_PKT_WIDTH = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

endpackage

// File: rtl/fg_packet_gen_if.sv
// Burst-descriptor input and AXI-stream output of the packet generator.
// master = the packet generator, slave = descriptor source plus stream sink.
interface fg_packet_gen_if
    import fg_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEST_WIDTH = BD_DEST_WIDTH,
    parameter int LEN_WIDTH  = BD_LEN_WIDTH
);
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    logic                  input_bd_valid;
    logic                  input_bd_ready;
    logic [DEST_WIDTH-1:0] input_bd_dest;
    logic [LEN_WIDTH-1:0]  input_bd_burst_len;

    logic [DATA_WIDTH-1:0] output_axis_tdata;
    logic [KEEP_WIDTH-1:0] output_axis_tkeep;
    logic                  output_axis_tvalid;
    logic                  output_axis_tready;
    logic                  output_axis_tlast;
    logic [DEST_WIDTH-1:0] output_axis_tdest;

    modport master (
        input  input_bd_valid,
        output input_bd_ready,
        input  input_bd_dest,
        input  input_bd_burst_len,
        output output_axis_tdata,
        output output_axis_tkeep,
        output output_axis_tvalid,
        input  output_axis_tready,
        output output_axis_tlast,
        output output_axis_tdest
    );

    modport slave (
        output input_bd_valid,
        input  input_bd_ready,
        output input_bd_dest,
        output input_bd_burst_len,
        input  output_axis_tdata,
        input  output_axis_tkeep,
        input  output_axis_tvalid,
        output output_axis_tready,
        input  output_axis_tlast,
        input  output_axis_tdest
    );

endinterface

// File: rtl/fg_beat_fill.sv
// Builds one payload beat: byte k carries (offset + k) mod 256 for the first
// nbytes lanes; unused lanes are zero and their keep bits cleared.
module fg_beat_fill #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int NB_WIDTH   = $clog2(KEEP_WIDTH + 1)
) (
    input  logic [7:0]            offset_i,
    input  logic [NB_WIDTH-1:0]   nbytes_i,
    output logic [DATA_WIDTH-1:0] tdata_o,
    output logic [KEEP_WIDTH-1:0] tkeep_o
);

    // Per-lane byte counter value and contiguous keep mask.
    always_comb begin
        tdata_o = {DATA_WIDTH{1'b0}};
        tkeep_o = {KEEP_WIDTH{1'b0}};
        for (int k = 0; k < KEEP_WIDTH; k++) begin
            if (NB_WIDTH'(k) < nbytes_i) begin
                tdata_o[8*k +: 8] = offset_i + 8'(k);
                tkeep_o[k]        = 1'b1;
            end else begin
                tdata_o[8*k +: 8] = 8'h00;
                tkeep_o[k]        = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fg_packet_gen.sv
// Packet generator: accepts burst descriptors and emits each burst as a train
// of AXI-stream packets of at most max_pkt_len bytes with a byte-counter payload.
// All stream outputs are registered; the next beat is prepared from next-state
// values so a new packet follows a tlast transfer without a bubble.
module fg_packet_gen
    import fg_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int DEST_WIDTH = BD_DEST_WIDTH,
    parameter int LEN_WIDTH  = BD_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fg_packet_gen_if.master       bus,
    input  logic [MAX_PKT_WIDTH-1:0] max_pkt_len,
    output logic                  busy,
    output logic [31:0]           bursts_done,
    output logic [LEN_WIDTH-1:0]  bytes_sent
);

    localparam int NB_WIDTH = $clog2(KEEP_WIDTH + 1);
    localparam logic [LEN_WIDTH-1:0] KEEP_LEN = LEN_WIDTH'(KEEP_WIDTH);
    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1'b1);

    state_t                state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic [LEN_WIDTH-1:0]  max_q, max_d;
    logic [LEN_WIDTH-1:0]  offset_q, offset_d;
    logic [LEN_WIDTH-1:0]  burst_rem_q, burst_rem_d;
    logic [LEN_WIDTH-1:0]  pkt_rem_q, pkt_rem_d;
    logic [NB_WIDTH-1:0]   nbytes_q, nbytes_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
    logic [DEST_WIDTH-1:0] tdest_q, tdest_d;
    logic [31:0]           bursts_q, bursts_d;
    logic [LEN_WIDTH-1:0]  bytes_q, bytes_d;

    logic                  load_beat_s;
    logic                  clear_beat_s;
    logic [LEN_WIDTH-1:0]  max_eff_s;
    logic [LEN_WIDTH-1:0]  nb_len_s;
    logic [LEN_WIDTH-1:0]  burst_left_s;
    logic [LEN_WIDTH-1:0]  pkt_left_s;
    logic [NB_WIDTH-1:0]   nbytes_new_s;
    logic [DATA_WIDTH-1:0] fill_data_s;
    logic [KEEP_WIDTH-1:0] fill_keep_s;

    // A zero max_pkt_len would never make progress, so it behaves as 1.
    assign max_eff_s    = (max_pkt_len == {MAX_PKT_WIDTH{1'b0}}) ? LEN_ONE
                                                                 : LEN_WIDTH'(max_pkt_len);
    assign nb_len_s     = LEN_WIDTH'(nbytes_q);
    assign burst_left_s = burst_rem_q - nb_len_s;
    assign pkt_left_s   = pkt_rem_q - nb_len_s;
    assign nbytes_new_s = (pkt_rem_d < KEEP_LEN) ? NB_WIDTH'(pkt_rem_d)
                                                 : NB_WIDTH'(KEEP_WIDTH);

    fg_beat_fill #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH),
        .NB_WIDTH   (NB_WIDTH)
    ) u_beat_fill (
        .offset_i (offset_d[7:0]),
        .nbytes_i (nbytes_new_s),
        .tdata_o  (fill_data_s),
        .tkeep_o  (fill_keep_s)
    );

    // FSM next state, burst/packet bookkeeping and status counters.
    always_comb begin
        state_d      = state_q;
        ready_d      = ready_q;
        busy_d       = busy_q;
        max_d        = max_q;
        offset_d     = offset_q;
        burst_rem_d  = burst_rem_q;
        pkt_rem_d    = pkt_rem_q;
        tdest_d      = tdest_q;
        bursts_d     = bursts_q;
        bytes_d      = bytes_q;
        load_beat_s  = 1'b0;
        clear_beat_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (bus.input_bd_valid && ready_q) begin
                    if (bus.input_bd_burst_len == LEN_ZERO) begin
                        // Empty burst completes immediately with no output.
                        bursts_d = bursts_q + 32'd1;
                    end else begin
                        state_d     = ST_SEND;
                        ready_d     = 1'b0;
                        busy_d      = 1'b1;
                        tdest_d     = bus.input_bd_dest;
                        max_d       = max_eff_s;
                        offset_d    = LEN_ZERO;
                        burst_rem_d = bus.input_bd_burst_len;
                        pkt_rem_d   = (max_eff_s < bus.input_bd_burst_len) ? max_eff_s
                                                                           : bus.input_bd_burst_len;
                        load_beat_s = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SEND: begin
                ready_d = 1'b0;
                busy_d  = 1'b1;
                if (tvalid_q && bus.output_axis_tready) begin
                    bytes_d     = bytes_q + nb_len_s;
                    offset_d    = offset_q + nb_len_s;
                    burst_rem_d = burst_left_s;
                    if (burst_left_s == LEN_ZERO) begin
                        state_d      = ST_IDLE;
                        ready_d      = 1'b1;
                        busy_d       = 1'b0;
                        bursts_d     = bursts_q + 32'd1;
                        pkt_rem_d    = LEN_ZERO;
                        clear_beat_s = 1'b1;
                    end else begin
                        if (pkt_left_s == LEN_ZERO) begin
                            pkt_rem_d = (max_q < burst_left_s) ? max_q : burst_left_s;
                        end else begin
                            pkt_rem_d = pkt_left_s;
                        end
                        load_beat_s = 1'b1;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end

            default: begin
                state_d      = ST_IDLE;
                ready_d      = 1'b0;
                busy_d       = 1'b0;
                clear_beat_s = 1'b1;
            end
        endcase
    end

    // Output beat register contents: load a fresh beat, clear after the burst, else hold.
    always_comb begin
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        nbytes_d = nbytes_q;
        if (load_beat_s) begin
            tvalid_d = 1'b1;
            tlast_d  = (pkt_rem_d <= KEEP_LEN);
            tdata_d  = fill_data_s;
            tkeep_d  = fill_keep_s;
            nbytes_d = nbytes_new_s;
        end else if (clear_beat_s) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tdata_d  = {DATA_WIDTH{1'b0}};
            tkeep_d  = {KEEP_WIDTH{1'b0}};
            nbytes_d = {NB_WIDTH{1'b0}};
        end else begin
            tvalid_d = tvalid_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            max_q       <= LEN_ONE;
            offset_q    <= LEN_ZERO;
            burst_rem_q <= LEN_ZERO;
            pkt_rem_q   <= LEN_ZERO;
            nbytes_q    <= {NB_WIDTH{1'b0}};
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= {DATA_WIDTH{1'b0}};
            tkeep_q     <= {KEEP_WIDTH{1'b0}};
            tdest_q     <= {DEST_WIDTH{1'b0}};
            bursts_q    <= 32'd0;
            bytes_q     <= LEN_ZERO;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            max_q       <= max_d;
            offset_q    <= offset_d;
            burst_rem_q <= burst_rem_d;
            pkt_rem_q   <= pkt_rem_d;
            nbytes_q    <= nbytes_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tdest_q     <= tdest_d;
            bursts_q    <= bursts_d;
            bytes_q     <= bytes_d;
        end
    end

    assign bus.input_bd_ready     = ready_q;
    assign bus.output_axis_tvalid = tvalid_q;
    assign bus.output_axis_tlast  = tlast_q;
    assign bus.output_axis_tdata  = tdata_q;
    assign bus.output_axis_tkeep  = tkeep_q;
    assign bus.output_axis_tdest  = tdest_q;
    assign busy                   = busy_q;
    assign bursts_done            = bursts_q;
    assign bytes_sent             = bytes_q;

endmodule
